// File: rtl/shift_reg_unit.sv
// Universal shift register: hold, load, shift, rotate and clear, plus an autonomous
// serialiser that streams a loaded word out on sout with busy/done status.
module shift_reg_unit #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] din,
  input  logic             sin,
  output logic [WIDTH-1:0] q,
  output logic             sout,
  output logic             busy,
  output logic             done
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  typedef enum logic {
    StIdle,
    StSer
  } state_e;

  typedef enum logic [2:0] {
    ModeHold     = 3'b000,
    ModeLoad     = 3'b001,
    ModeShl      = 3'b010,
    ModeShr      = 3'b011,
    ModeRol      = 3'b100,
    ModeRor      = 3'b101,
    ModeSerStart = 3'b110,
    ModeClear    = 3'b111
  } mode_e;

  state_e          state_q;
  logic [CntW-1:0] cnt_q;
  logic [WIDTH-1:0] q_q;
  logic             done_q;

  logic [WIDTH-1:0] shl_word;
  logic [WIDTH-1:0] shr_word;
  logic [WIDTH-1:0] rol_word;
  logic [WIDTH-1:0] ror_word;
  logic [WIDTH-1:0] ser_word;

  assign shl_word = {q_q[WIDTH-2:0], sin};
  assign shr_word = {sin, q_q[WIDTH-1:1]};
  assign rol_word = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
  assign ror_word = {q_q[0], q_q[WIDTH-1:1]};
  // The serialiser always moves the next stream bit toward the sout end.
  assign ser_word = MSB_FIRST ? shl_word : shr_word;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      q_q     <= '0;
      done_q  <= 1'b0;
    end else if (!en) begin
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          unique case (mode_e'(mode))
            ModeHold:     q_q <= q_q;
            ModeLoad:     q_q <= din;
            ModeShl:      q_q <= shl_word;
            ModeShr:      q_q <= shr_word;
            ModeRol:      q_q <= rol_word;
            ModeRor:      q_q <= ror_word;
            ModeSerStart: begin
              q_q     <= din;
              cnt_q   <= '0;
              state_q <= StSer;
            end
            ModeClear:    q_q <= '0;
          endcase
        end
        StSer: begin
          // Mode is deliberately ignored until the stream has finished.
          q_q <= ser_word;
          if (cnt_q == CntLast) begin
            cnt_q   <= '0;
            state_q <= StIdle;
            done_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
      endcase
    end
  end

  assign q    = q_q;
  assign sout = MSB_FIRST ? q_q[WIDTH-1] : q_q[0];
  assign busy = (state_q == StSer);
  assign done = done_q;

endmodule
